// File: rtl/bcd_stopwatch_mux.sv
// bcd_stopwatch_mux: DIGITS-wide cascaded BCD stopwatch with a tick prescaler,
// start/stop/single-step control, 2-flop input synchronisers, a sticky
// overflow flag and a time-multiplexed active-low 7-segment scan driver.
// Optional lap display freeze: define BCD_STOPWATCH_LAP_EN to build the
// lap latch; without it the lap port is ignored.
module bcd_stopwatch_mux #(
   parameter int TICK_DIV = 100000,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 65536,
   parameter int DP_DIGIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              switch,
   input  logic              inc,
   input  logic              lap,
   output logic [7:0]        num,
   output logic [DIGITS-1:0] loc,
   output logic              running,
   output logic              overflow
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Active-low abcdefg pattern for one BCD digit; blank on an illegal code.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic                   sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
   logic                   inc_meta_q, inc_meta_d, inc_sync_q, inc_sync_d;
   logic                   inc_prev_q, inc_prev_d;
   logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
   state_t                 state_q, state_d;
   logic                   running_q, running_d;
   logic [DIGITS-1:0][3:0] digits_q, digits_d;
   logic                   overflow_q, overflow_d;
   logic [SW-1:0]          scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]          scan_idx_q, scan_idx_d;
   logic [7:0]             num_q, num_d;
   logic [DIGITS-1:0]      loc_q, loc_d;

   logic                   inc_rise_s;
   logic                   tick_s;
   logic                   count_en_s;
   logic [DIGITS-1:0][3:0] show_digits_s;
   logic [3:0]             disp_digit_s;
   logic                   dp_s;

   // Two-flop synchronisers for the asynchronous switch and inc inputs.
   always_comb begin
      sw_meta_d  = switch;
      sw_sync_d  = sw_meta_q;
      inc_meta_d = inc;
      inc_sync_d = inc_meta_q;
      inc_prev_d = inc_sync_q;
      inc_rise_s = inc_sync_q & ~inc_prev_q;
   end

   // Free-running tick prescaler; tick is the last count of each period.
   always_comb begin
      tick_s = (tick_cnt_q >= TICK_LAST);
      if (tick_s) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end
   end

   // Control FSM: next state and the single count enable for the digit chain.
   always_comb begin
      state_d    = state_q;
      count_en_s = 1'b0;
      case (state_q)
         ST_STOP: begin
            if (sw_sync_q) begin
               state_d = ST_RUN;
            end else if (inc_rise_s) begin
               state_d = ST_STEP;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_RUN: begin
            count_en_s = tick_s;
            if (!sw_sync_q) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_STEP: begin
            // One forced increment; ticks are never looked at outside RUN.
            count_en_s = 1'b1;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            // Wait for the button to be released before accepting switch again.
            if (!inc_sync_q) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
      running_d = (state_d == ST_RUN);
   end

   // Cascaded BCD increment; a carry out of the top digit marks the wrap.
   always_comb begin : p_count
      logic carry_s;
      digits_d = digits_q;
      carry_s  = count_en_s;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry_s) begin
            if (digits_q[k] >= 4'd9) begin
               digits_d[k] = 4'd0;
            end else begin
               digits_d[k] = digits_q[k] + 4'd1;
               carry_s     = 1'b0;
            end
         end else begin
            digits_d[k] = digits_q[k];
         end
      end
      if (carry_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Scan prescaler and digit index rotation.
   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q >= SCAN_LAST) begin
         scan_cnt_d = '0;
         if (scan_idx_q >= IDX_LAST) begin
            scan_idx_d = '0;
         end else begin
            scan_idx_d = scan_idx_q + IW'(1);
         end
      end else begin
         scan_idx_d = scan_idx_q;
      end
   end

`ifdef BCD_STOPWATCH_LAP_EN
   logic                   lap_meta_q, lap_meta_d, lap_sync_q, lap_sync_d;
   logic                   lap_prev_q, lap_prev_d;
   logic [DIGITS-1:0][3:0] lap_latch_q, lap_latch_d;
   logic                   lap_rise_s;

   // Lap synchroniser, capture on the synced rising edge, and display source.
   always_comb begin
      lap_meta_d  = lap;
      lap_sync_d  = lap_meta_q;
      lap_prev_d  = lap_sync_q;
      lap_rise_s  = lap_sync_q & ~lap_prev_q;
      lap_latch_d = lap_latch_q;
      if (lap_rise_s) begin
         lap_latch_d = digits_q;
      end else begin
         lap_latch_d = lap_latch_q;
      end
      // On the capture cycle the live digits are exactly what is being latched.
      if (lap_sync_q && !lap_rise_s) begin
         show_digits_s = lap_latch_q;
      end else begin
         show_digits_s = digits_q;
      end
   end

   // Lap state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_meta_q  <= 1'b0;
         lap_sync_q  <= 1'b0;
         lap_prev_q  <= 1'b0;
         lap_latch_q <= '0;
      end else begin
         lap_meta_q  <= lap_meta_d;
         lap_sync_q  <= lap_sync_d;
         lap_prev_q  <= lap_prev_d;
         lap_latch_q <= lap_latch_d;
      end
   end
`else
   logic unused_lap_s;

   // Without the lap feature the display always follows the live count.
   always_comb begin
      unused_lap_s  = lap;
      show_digits_s = digits_q;
   end
`endif

   // Segment and digit-enable patterns for the currently selected position.
   always_comb begin
      disp_digit_s = show_digits_s[scan_idx_q];
      if (int'(scan_idx_q) == DP_DIGIT) begin
         dp_s = 1'b0;
      end else begin
         dp_s = 1'b1;
      end
      num_d = {seg_decode(disp_digit_s), dp_s};
      loc_d = ~(DIGITS'(1) << scan_idx_q);
   end

   // All core state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_q  <= 1'b0;
         sw_sync_q  <= 1'b0;
         inc_meta_q <= 1'b0;
         inc_sync_q <= 1'b0;
         inc_prev_q <= 1'b0;
         tick_cnt_q <= '0;
         state_q    <= ST_STOP;
         running_q  <= 1'b0;
         digits_q   <= '0;
         overflow_q <= 1'b0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         num_q      <= 8'hFF;
         loc_q      <= {DIGITS{1'b1}};
      end else begin
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
         inc_meta_q <= inc_meta_d;
         inc_sync_q <= inc_sync_d;
         inc_prev_q <= inc_prev_d;
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         running_q  <= running_d;
         digits_q   <= digits_d;
         overflow_q <= overflow_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         num_q      <= num_d;
         loc_q      <= loc_d;
      end
   end

   assign num      = num_q;
   assign loc      = loc_q;
   assign running  = running_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
// Testbench for bcd_stopwatch_mux: phase table, hand sequences for the
// overflow/reset/lap corners and random stimulus, all checked against a
// cycle-level reference model using integer count arithmetic.
`timescale 1ns/1ps
module tb_bcd_stopwatch_mux;

   localparam int TICK_DIV = 4;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 2;
   localparam int DP_DIGIT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       switch = 1'b0;
   logic       inc = 1'b0;
   logic       lap = 1'b0;
   logic [7:0] num;
   logic [3:0] loc;
   logic       running;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   bcd_stopwatch_mux #(
      .TICK_DIV(TICK_DIV), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DP_DIGIT(DP_DIGIT)
   ) dut (
      .clk(clk), .rst(rst), .switch(switch), .inc(inc), .lap(lap),
      .num(num), .loc(loc), .running(running), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   typedef enum int {M_STOP, M_RUN, M_STEP, M_HOLD} mmode_t;
   mmode_t     m_mode;
   int         m_count, m_latch, m_cyc;
   bit         m_ovf, m_run;
   bit         m_sw1, m_sw2, m_inc1, m_inc2, m_incp, m_lap1, m_lap2, m_lapp;
   logic [7:0] m_num;
   logic [3:0] m_loc;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int seg2dig(input logic [6:0] s);
      for (int d = 0; d < 10; d++) begin
         if (seg7(d) === s) return d;
      end
      return -1;
   endfunction

   task automatic model_step();
      int idx, shown, d;
      bit tick, rise, en;
      mmode_t nxt;
      if (rst) begin
         m_mode = M_STOP; m_count = 0; m_latch = 0; m_cyc = 0;
         m_ovf = 1'b0; m_run = 1'b0;
         m_sw1 = 1'b0; m_sw2 = 1'b0; m_inc1 = 1'b0; m_inc2 = 1'b0; m_incp = 1'b0;
         m_lap1 = 1'b0; m_lap2 = 1'b0; m_lapp = 1'b0;
         m_num = 8'hFF; m_loc = 4'hF;
         return;
      end
      tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      rise = m_inc2 && !m_incp;
      en   = 1'b0;
      nxt  = m_mode;
      case (m_mode)
         M_STOP:  nxt = m_sw2 ? M_RUN : (rise ? M_STEP : M_STOP);
         M_RUN:   begin en = tick; nxt = m_sw2 ? M_RUN : M_STOP; end
         M_STEP:  begin en = 1'b1; nxt = M_HOLD; end
         default: nxt = m_inc2 ? M_HOLD : M_STOP;
      endcase
`ifdef BCD_STOPWATCH_LAP_EN
      if (m_lap2 && !m_lapp) m_latch = m_count;
      shown = m_lap2 ? m_latch : m_count;
`else
      shown = m_count;
`endif
      idx   = (m_cyc / SCAN_DIV) % DIGITS;
      d     = (shown / (10 ** idx)) % 10;
      m_num = {seg7(d), (idx == DP_DIGIT) ? 1'b0 : 1'b1};
      m_loc = ~(4'b0001 << idx);
      if (en) begin
         if (m_count == 9999) begin
            m_count = 0;
            m_ovf   = 1'b1;
         end else begin
            m_count = m_count + 1;
         end
      end
      m_mode = nxt;
      m_run  = (nxt == M_RUN);
      m_sw2  = m_sw1;  m_sw1  = switch;
      m_incp = m_inc2; m_inc2 = m_inc1; m_inc1 = inc;
      m_lapp = m_lap2; m_lap2 = m_lap1; m_lap1 = lap;
      m_cyc  = m_cyc + 1;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      checks++;
      if ({num, loc, running, overflow} !== {m_num, m_loc, m_run, m_ovf}) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t: got num=%b loc=%b run=%b ovf=%b expected num=%b loc=%b run=%b ovf=%b",
                  $time, num, loc, running, overflow, m_num, m_loc, m_run, m_ovf);
      end
   endtask

   // Walk the scan once around and decode the displayed value from num/loc.
   task automatic read_display(output int val);
      int dig[DIGITS];
      bit ok;
      for (int k = 0; k < DIGITS; k++) dig[k] = -1;
      for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
         step();
         for (int k = 0; k < DIGITS; k++) begin
            if (loc == ~(4'b0001 << k)) dig[k] = seg2dig(num[7:1]);
         end
      end
      ok  = 1'b1;
      val = 0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (dig[k] < 0) ok = 1'b0;
         val = val * 10 + dig[k];
      end
      if (!ok) val = -1;
   endtask

   task automatic pulse_inc();
      inc = 1'b1;
      repeat (4) step();
      inc = 1'b0;
      repeat (5) step();
   endtask

   task automatic run_until(input int target, input int limit);
      int n;
      n = 0;
      while (m_count != target && n < limit) begin
         step();
         n++;
      end
      if (n >= limit) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for count %0d: got %0d", target, m_count);
      end
   endtask

   typedef struct {
      bit sw;
      bit inc;
      int ncyc;
      int exp_count;   // -1: display not read
      bit exp_run;
      bit exp_ovf;
   } phase_t;

   phase_t tbl[10];

   initial begin
      int v;
      int n;
      tbl[0] = '{1'b1, 1'b0, 40, -1, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 10, 10, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1,  5, -1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0,  5, 11, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1,  5, -1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0,  5, 12, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1,  5, -1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0,  5, 13, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 20, -1, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0,  6, 14, 1'b0, 1'b0};

      // Reset for two cycles, then the first scan update.
      rst = 1'b1;
      step();
      chk("reset_num", int'(num), 8'hFF);
      chk("reset_loc", int'(loc), 4'hF);
      chk("reset_running", int'(running), 0);
      chk("reset_overflow", int'(overflow), 0);
      step();
      rst = 1'b0;
      step();
      chk("first_scan_loc", int'(loc), 4'b1110);
      chk("first_scan_num", int'(num), 8'b00000011);

      // Run / stop / single-step phases.
      for (int i = 0; i < 10; i++) begin
         switch = tbl[i].sw;
         inc    = tbl[i].inc;
         repeat (tbl[i].ncyc) step();
         chk($sformatf("phase%0d_running", i), int'(running), int'(tbl[i].exp_run));
         chk($sformatf("phase%0d_overflow", i), int'(overflow), int'(tbl[i].exp_ovf));
         if (tbl[i].exp_count >= 0) begin
            read_display(v);
            chk($sformatf("phase%0d_count", i), v, tbl[i].exp_count);
         end
      end

      // Run close to the top, then single-step through the wrap.
      switch = 1'b1;
      n = 0;
      while (m_count < 9990 && n < 45000) begin
         step();
         n++;
      end
      switch = 1'b0;
      repeat (6) step();
      read_display(v);
      chk("near_top_count", v, m_count);
      n = 0;
      while (m_count < 9999 && n < 20) begin
         pulse_inc();
         n++;
      end
      read_display(v);
      chk("all_nines_count", v, 9999);
      chk("all_nines_overflow", int'(overflow), 0);
      pulse_inc();
      read_display(v);
      chk("wrap_count", v, 0);
      chk("wrap_overflow", int'(overflow), 1);
      switch = 1'b1;
      repeat (30) step();
      chk("overflow_sticky", int'(overflow), 1);

      // Mid-run reset with switch still high.
      run_until(123, 2000);
      rst = 1'b1;
      step();
      chk("midrun_rst_running", int'(running), 0);
      chk("midrun_rst_overflow", int'(overflow), 0);
      chk("midrun_rst_num", int'(num), 8'hFF);
      chk("midrun_rst_loc", int'(loc), 4'hF);
      rst = 1'b0;
      step();
      chk("resume_running_c1", int'(running), 0);
      step();
      chk("resume_running_c2", int'(running), 0);
      step();
      chk("resume_running_c3", int'(running), 1);
      switch = 1'b0;
      repeat (6) step();
      read_display(v);
      chk("after_rst_count", v, m_count);

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) switch = ~switch;
         if ($urandom_range(0, 5) == 0) inc = ~inc;
         if ($urandom_range(0, 19) == 0) lap = ~lap;
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; switch = 1'b0; inc = 1'b0; lap = 1'b0;
      repeat (6) step();

`ifdef BCD_STOPWATCH_LAP_EN
      // Lap freeze while counting continues.
      rst = 1'b1;
      step();
      rst = 1'b0;
      switch = 1'b1;
      run_until(42, 400);
      lap = 1'b1;
      repeat (4) step();
      read_display(v);
      chk("lap_frozen_value", v, 42);
      repeat (18) step();
      read_display(v);
      chk("lap_still_frozen", v, 42);
      lap = 1'b0;
      switch = 1'b0;
      repeat (8) step();
      read_display(v);
      chk("lap_released_live", v, m_count);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_stopwatch_mux.md
Name: bcd_stopwatch_mux

Overview:
- Parametrised successor to the fixed 4-digit millisecond timer.
- DIGITS-wide cascaded BCD stopwatch with a configurable tick prescaler, start/stop/single-step control and synchronised inputs.
- Sticky overflow flag and a time-multiplexed, active-low 7-segment scan driver.
- Sits between board switches/buttons and the seven-segment display; one clock domain.

Parameters:
- TICK_DIV, 100000: clk cycles per count tick (1 ms at 100 MHz); legal range ≥2.
- DIGITS, 4: number of BCD digits and display positions; legal range 2..8.
- SCAN_DIV, 65536: clk cycles each digit is displayed before the scan advances; legal range ≥1.
- DP_DIGIT, 3: digit index (0 = least significant) whose decimal point is lit.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- switch, input, 1: level; 1 = run, 0 = stop; asynchronous to clk.
- inc, input, 1: level button; a rising edge while stopped adds one count; asynchronous.
- lap, input, 1: level; 1 freezes the displayed value (LAP_EN only; ignored otherwise).
- num, output, 8: segments {a,b,c,d,e,f,g,dp}, bit7 = a, active low.
- loc, output, DIGITS: digit enables, active low, one-hot-zero; bit k = digit k.
- running, output, 1: 1 while FSM is in RUN.
- overflow, output, 1: sticky; set when the counter wraps from all-9s to all-0s.

Behaviour:
- **Reset.** rst is sampled on posedge clk and overrides everything. The next cycle shows:
  - all digits 0, FSM = STOP, prescaler = 0, scan index = 0, scan prescaler = 0;
  - num = 8'hFF, loc = all ones, running = 0, overflow = 0;
  - synchroniser flops = 0.
  - Mid-run reset takes effect identically.
- **Input synchronisation.**
  - switch, inc and lap each pass through 2 flops before use (2-cycle input latency).
  - inc_rise = synced inc AND NOT the previous synced inc.
- **Tick generator.**
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for exactly one clk cycle when counter == TICK_DIV-1.
  - The counter free-runs in every state.
- **FSM** (states STOP, RUN, STEP, HOLD):
  - STOP: synced switch = 1 → RUN. Else inc_rise → STEP. Else stay.
  - RUN: increment the counter on every tick. synced switch = 0 → STOP.
  - STEP: lasts exactly one cycle and increments the counter once, independent of tick. Then → HOLD.
  - HOLD: no increment. Leave for STOP when synced inc = 0. The synced switch is ignored until then.
  - running = (state == RUN), registered from the state.
  - Any tick arriving in STOP, STEP or HOLD is ignored, so STEP never produces a double increment.
- **Counter arithmetic.**
  - Digit 0 increments on each enable.
  - Digit k increments when the enable is active and digits 0..k-1 are all 9.
  - A digit at 9 that increments becomes 0.
  - Value range is 0 to 10^DIGITS - 1.
  - Wrap from all-9s to all-0s sets overflow in the same cycle the digits clear. overflow stays set until rst.
  - Digit values never leave 0..9.
- **Display scan.**
  - The scan prescaler counts 0..SCAN_DIV-1.
  - At wrap, the scan index advances k → k+1, and DIGITS-1 → 0.
  - num and loc are registered, one cycle after the index changes. At that point:
    - loc has bit[index] = 0 and all other bits = 1;
    - num carries the segment pattern of the shown digit.
  - Segment codes, active low, abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - dp = 0 (lit) only when index == DP_DIGIT; otherwise dp = 1.
  - Source digits are the live counter, or the lap latch under LAP_EN.

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_EN.
- Defined:
  - On a synced-lap rising edge, the current digits are copied into a DIGITS×4 lap latch.
  - While synced lap = 1, the scan displays the latch; counting continues underneath.
  - When lap = 0, the scan displays the live digits.
  - rst clears the latch to 0.
- Not defined: the lap port exists but is unused, no latch is built, and the display always shows the live digits.

Test Plan:
- All tests use TICK_DIV=4, DIGITS=4, SCAN_DIV=2, DP_DIGIT=3.
- rst for 2 cycles, then release → num=8'hFF and loc=4'b1111 during reset; after the first scan update, loc=4'b1110 and num=8'b00000011.
- switch=1 held for 40 clk cycles, then 0 → running=1 starting 3 cycles after switch; count increments once per 4 cycles, reaching about 0009 then 0010 (digit-1 carry); count freezes after switch drops and the synchroniser delay.
- In STOP, three inc pulses of 5 cycles each, separated by 5 low cycles → count advances exactly 3; holding inc high for 20 cycles yields +1 only.
- Preload 9999 by running, then one more tick → digits 0000, overflow=1; overflow stays 1 after further counting until rst.
- Assert rst mid-RUN at count 0123 → next cycle: digits 0, running=0, FSM STOP, even with switch still 1; after release, RUN resumes 3 cycles later.
- LAP_EN defined: run to 0042, lap=1 for 30 cycles → display holds 0042 on all four positions while the internal count passes 0049; lap=0 → live value displayed; the digit with index 3 shows dp=0 throughout.
